decode_stage: RTL and testbench

- Instruction Decode stage of the 5-stage MIPS pipeline.
- Consumes the IF/ID register outputs (instrD, pcD, pcplus4D) and holds the 32x32 register file, which the Writeback stage writes.
- Decodes control, sign-extends the immediate and registers everything into the ID/EX pipeline register for Execute.
- flushE inserts a bubble after a taken branch resolves in Execute.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/reg_file_2r1w.sv | 42 ++++
 rtl/decode_stage.sv | 177 +++++++++++++++++
 tb/tb_decode_stage.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, functs, ALU codes and the decoded control bundle.
// Fetch, Decode and Execute all import this package.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic       jump;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file with two combinational reads and one synchronous write.
// $0 is hardwired to zero; a same-cycle write is forwarded to matching reads.
module reg_file_2r1w #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i
);

  logic [NREG-1:0][DW-1:0] mem_q;
  logic                    wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Bypass lets the ID/EX register latch the value Writeback is committing this cycle.
  always_comb begin
    rd1_o = mem_q[ra1_i];
    rd2_o = mem_q[ra2_i];
    if (wr_en && (wa_i == ra1_i)) rd1_o = wd_i;
    if (wr_en && (wa_i == ra2_i)) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS Instruction Decode stage: control decode, register read, immediate sign-extension,
// and the ID/EX pipeline register. flushE turns the captured instruction into a bubble.
module decode_stage
  import mips_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instrD,
  input  logic [DW-1:0] pcD,
  input  logic [DW-1:0] pcplus4D,
  input  logic          flushE,
  input  logic          regwriteW,
  input  logic [AW-1:0] rdW,
  input  logic [DW-1:0] resultW,
  output logic          regwriteE,
  output logic          memtoregE,
  output logic          memwriteE,
  output logic          branchE,
  output logic          alusrcE,
  output logic          regdstE,
  output logic          jumpE,
  output logic [2:0]    alucontrolE,
  output logic [DW-1:0] rd1E,
  output logic [DW-1:0] rd2E,
  output logic [AW-1:0] rsE,
  output logic [AW-1:0] rtE,
  output logic [AW-1:0] rdE,
  output logic [DW-1:0] immE,
  output logic [DW-1:0] pcE,
  output logic [DW-1:0] pcplus4E,
  output logic          illegalE
);

  logic [5:0]    op, funct;
  logic [AW-1:0] rs, rt, rd;
  logic [DW-1:0] rd1, rd2, imm;
  ctrl_t         ctrl;

  assign op    = instrD[31:26];
  assign funct = instrD[5:0];
  assign rs    = instrD[25:21];
  assign rt    = instrD[20:16];
  assign rd    = instrD[15:11];
  assign imm   = {{(DW-16){instrD[15]}}, instrD[15:0]};

  reg_file_2r1w #(.NREG(NREG), .DW(DW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  (regwriteW),
    .wa_i  (rdW),
    .wd_i  (resultW)
  );

  always_comb begin
    ctrl = '0;
    if (instrD != 32'h0) begin
      case (op)
        OP_RTYPE: begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
          case (funct)
            F_ADD:   ctrl.alucontrol = ALU_ADD;
            F_SUB:   ctrl.alucontrol = ALU_SUB;
            F_AND:   ctrl.alucontrol = ALU_AND;
            F_OR:    ctrl.alucontrol = ALU_OR;
            F_SLT:   ctrl.alucontrol = ALU_SLT;
            default: begin
              ctrl         = '0;
              ctrl.illegal = 1'b1;
            end
          endcase
        end
        OP_LW: begin
          ctrl.regwrite   = 1'b1;
          ctrl.memtoreg   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        OP_SW: begin
          ctrl.memwrite   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        OP_BEQ: begin
          ctrl.branch     = 1'b1;
          ctrl.alucontrol = ALU_SUB;
        end
        OP_ADDI: begin
          ctrl.regwrite   = 1'b1;
          ctrl.alusrc     = 1'b1;
          ctrl.alucontrol = ALU_ADD;
        end
        OP_J:    ctrl.jump    = 1'b1;
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

  // ID/EX pipeline register
  ctrl_t         ctrl_q, ctrl_d;
  logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d, pc4_q, pc4_d;
  logic [AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

  always_comb begin
    ctrl_d = ctrl;
    rd1_d  = rd1;
    rd2_d  = rd2;
    imm_d  = imm;
    pc_d   = pcD;
    pc4_d  = pcplus4D;
    rs_d   = rs;
    rt_d   = rt;
    rd_d   = rd;
    if (flushE) begin
      ctrl_d = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      pc_d   = '0;
      pc4_d  = '0;
      rs_d   = '0;
      rt_d   = '0;
      rd_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      pc4_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      pc4_q  <= pc4_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign regwriteE   = ctrl_q.regwrite;
  assign memtoregE   = ctrl_q.memtoreg;
  assign memwriteE   = ctrl_q.memwrite;
  assign branchE     = ctrl_q.branch;
  assign alusrcE     = ctrl_q.alusrc;
  assign regdstE     = ctrl_q.regdst;
  assign jumpE       = ctrl_q.jump;
  assign alucontrolE = ctrl_q.alucontrol;
  assign illegalE    = ctrl_q.illegal;
  assign rd1E        = rd1_q;
  assign rd2E        = rd2_q;
  assign immE        = imm_q;
  assign pcE         = pc_q;
  assign pcplus4E    = pc4_q;
  assign rsE         = rs_q;
  assign rtE         = rt_q;
  assign rdE         = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; control outputs are compared as one packed vector
// {regwrite,memtoreg,memwrite,branch,alusrc,regdst,jump,alucontrol[2:0],illegal}.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD, pcD, pcplus4D;
  logic        flushE, regwriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic        regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE, jumpE, illegalE;
  logic [2:0]  alucontrolE;
  logic [31:0] rd1E, rd2E, immE, pcE, pcplus4E;
  logic [4:0]  rsE, rtE, rdE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
    .flushE(flushE), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
    .branchE(branchE), .alusrcE(alusrcE), .regdstE(regdstE), .jumpE(jumpE),
    .alucontrolE(alucontrolE), .rd1E(rd1E), .rd2E(rd2E), .rsE(rsE), .rtE(rtE),
    .rdE(rdE), .immE(immE), .pcE(pcE), .pcplus4E(pcplus4E), .illegalE(illegalE)
  );

  logic [10:0] ctrl;
  assign ctrl = {regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE, jumpE,
                 alucontrolE, illegalE};

  localparam logic [10:0] C_RTYPE_ADD = 11'b1000010_010_0;
  localparam logic [10:0] C_LW        = 11'b1100100_010_0;
  localparam logic [10:0] C_SW        = 11'b0010100_010_0;
  localparam logic [10:0] C_BEQ       = 11'b0001000_110_0;
  localparam logic [10:0] C_ADDI      = 11'b1000100_010_0;
  localparam logic [10:0] C_J         = 11'b0000001_000_0;
  localparam logic [10:0] C_ILL       = 11'b0000000_000_1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, clock it, then sample 1ns after the edge.
  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    rst = r; instrD = ins; pcD = pc; pcplus4D = pc + 32'd4; flushE = fl;
    regwriteW = we; rdW = wa; resultW = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, 32'h8C820004, 32'h40, 1'b0, 1'b1, 5'd2, 32'hAAAA5555);
    step(1'b1, 32'h8C820004, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("rst_ctrl", {21'h0, ctrl}, 32'h0);
    chk("rst_rd1", rd1E, 32'h0);
    chk("rst_imm", immE, 32'h0);
    chk("rst_pc", pcE, 32'h0);
    chk("rst_pc4", pcplus4E, 32'h0);
    chk("rst_fields", {17'h0, rsE, rtE, rdE}, 32'h0);

    // add $3,$2,$2 right after reset: the write during reset must be gone
    step(1'b0, 32'h00421820, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("post_rst_rd1", rd1E, 32'h0);
    chk("add_ctrl", {21'h0, ctrl}, {21'h0, C_RTYPE_ADD});
    chk("add_rd", {27'h0, rdE}, 32'd3);

    step(1'b0, 32'h8C820004, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("lw_ctrl", {21'h0, ctrl}, {21'h0, C_LW});
    chk("lw_rs", {27'h0, rsE}, 32'd4);
    chk("lw_rt", {27'h0, rtE}, 32'd2);
    chk("lw_imm", immE, 32'h00000004);
    chk("lw_pc", pcE, 32'h10);
    chk("lw_pc4", pcplus4E, 32'h14);

    step(1'b0, 32'h2008FFFF, 32'h14, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("addi_ctrl", {21'h0, ctrl}, {21'h0, C_ADDI});
    chk("addi_imm", immE, 32'hFFFFFFFF);

    // add $6,$5,$5 with same-cycle writeback of $5
    step(1'b0, 32'h00A53020, 32'h18, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("byp_rd1", rd1E, 32'hDEADBEEF);
    chk("byp_rd2", rd2E, 32'hDEADBEEF);
    step(1'b0, 32'h00A53022, 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("stored_rd1", rd1E, 32'hDEADBEEF);
    chk("sub_alu", {29'h0, alucontrolE}, 32'b110);

    // write to $0 while reading it, then read again
    step(1'b0, 32'h00000820, 32'h20, 1'b0, 1'b1, 5'd0, 32'h1234);
    chk("r0_byp", rd1E, 32'h0);
    step(1'b0, 32'h00000820, 32'h24, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("r0_read", rd2E, 32'h0);

    // flushed sw with a same-cycle writeback to $3
    step(1'b0, 32'hAC820008, 32'h28, 1'b1, 1'b1, 5'd3, 32'h55);
    chk("flush_ctrl", {21'h0, ctrl}, 32'h0);
    chk("flush_imm", immE, 32'h0);
    chk("flush_pc", pcE, 32'h0);
    step(1'b0, 32'h00631020, 32'h2C, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("flush_wb_rd1", rd1E, 32'h55);
    chk("flush_wb_rd2", rd2E, 32'h55);

    step(1'b0, 32'hAC820008, 32'h30, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("sw_ctrl", {21'h0, ctrl}, {21'h0, C_SW});
    step(1'b0, 32'h1085FFFE, 32'h34, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("beq_ctrl", {21'h0, ctrl}, {21'h0, C_BEQ});
    chk("beq_imm", immE, 32'hFFFFFFFE);
    step(1'b0, 32'h08000010, 32'h38, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("j_ctrl", {21'h0, ctrl}, {21'h0, C_J});
    step(1'b0, 32'h00A53024, 32'h3C, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("and_alu", {29'h0, alucontrolE}, 32'b000);
    step(1'b0, 32'h00A53025, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("or_alu", {29'h0, alucontrolE}, 32'b001);
    step(1'b0, 32'h00A5302A, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("slt_alu", {29'h0, alucontrolE}, 32'b111);

    step(1'b0, 32'hFC000000, 32'h48, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("ill_op", {21'h0, ctrl}, {21'h0, C_ILL});
    step(1'b0, 32'h00000027, 32'h4C, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("ill_nor", {21'h0, ctrl}, {21'h0, C_ILL});
    step(1'b0, 32'h00000000, 32'h50, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("nop_ctrl", {21'h0, ctrl}, 32'h0);

    // rst beats flushE and discards a same-cycle write to $7
    step(1'b0, 32'h2008FFFF, 32'h54, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h2008FFFF, 32'h58, 1'b1, 1'b1, 5'd7, 32'h99);
    chk("rst_flush_ctrl", {21'h0, ctrl}, 32'h0);
    step(1'b0, 32'h00E73820, 32'h5C, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("rst_drop_wb", rd1E, 32'h0);
    chk("rst_clears_r5", {27'h0, rsE}, 32'd7);
    step(1'b0, 32'h00A53020, 32'h60, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("rst_cleared_r5", rd1E, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
